// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and sizing helpers for serial_subtractor
package serial_subtractor_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational subtract cell, d = a - b - br with borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);
  assign d_o  = a_i ^ b_i ^ br_i;
  assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - B_IN, LSB first, behind a START/DONE handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             B_OUT,
  output logic             OVF
`else
  output logic             B_OUT
`endif
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q, busy_q, done_q;
  logic             d_bit, br_d, last;
  logic [WIDTH-1:0] r_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q;
  assign OVF = ovf_q;
`endif
  full_subtractor u_fs (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .br_i(br_q),
    .d_o (d_bit),
    .br_o(br_d)
  );
  assign r_d   = {d_bit, r_q[WIDTH-1:1]};
  assign last  = cnt_q == CW'(WIDTH - 1);
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign D     = d_q;
  assign B_OUT = bout_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == S_RUN) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        r_q   <= r_d;
        br_q  <= br_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          d_q     <= r_d;
          bout_q  <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // signed overflow: borrow into MSB differs from borrow out of MSB
          ovf_q   <= br_q ^ br_d;
`endif
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else if (START) begin
        a_q     <= A;
        b_q     <= B;
        br_q    <= B_IN;
        cnt_q   <= '0;
        state_q <= S_RUN;
        busy_q  <= 1'b1;
      end else begin
        state_q <= S_IDLE;
      end
    end
  end
endmodule
